// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the digit-counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit counter width for n digits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder cell, chained by the top level into a DIGIT-wide ripple slice.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: captures a, b, cin on start, then adds DIGIT bits per
// cycle (LSB digit first) through a ripple slice of full adders.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; sum/cout hold the last result
// RUN     | one digit per cycle, N cycles total; busy=1
// DONE    | single cycle, done=1; start here launches the next addition
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int N        = WIDTH / DIG_SAFE;
  localparam int CNT_W    = cnt_width(N);

  generate
    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIG_SAFE) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT, DIGIT >= 1");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT:0]     w_carry;
  logic [DIGIT-1:0]   w_dsum;

  // Ripple slice over the current low digit of the operand shift registers.
  assign w_carry[0] = r_carry;
  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    fulladder u_fa (
      .i_a    (r_a[g]),
      .i_b    (r_b[g]),
      .i_cin  (w_carry[g]),
      .o_sum  (w_dsum[g]),
      .o_cout (w_carry[g+1])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a load happens whenever start is accepted outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operands shift down one digit per RUN cycle, result digits
  // enter sum from the top so the full word is aligned after N cycles.
  // The counter runs down from N-1; zero marks the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= CNT_W'(N - 1);
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= (r_sum >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
      r_carry <= w_carry[DIGIT];
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three adder configurations (8/1, 8/4, 1/1) checked
// against an arithmetic model of a+b+cin.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st   [3];
  logic [7:0] op_a [3];
  logic [7:0] op_b [3];
  logic       op_c [3];

  logic       o0_busy, o0_done, o0_cout;
  logic [7:0] o0_sum;
  logic       o1_busy, o1_done, o1_cout;
  logic [7:0] o1_sum;
  logic       o2_busy, o2_done, o2_cout;
  logic       o2_sum;

  logic       m_busy [3];
  logic       m_done [3];
  logic       m_cout [3];
  logic [7:0] m_sum  [3];

  int wid [3] = '{8, 8, 1};
  int nd  [3] = '{8, 2, 1};

  int n_total = 0;
  int n_bad   = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_a8d1 (
    .clk(clk), .rst(rst), .start(st[0]), .a(op_a[0]), .b(op_b[0]), .cin(op_c[0]),
    .busy(o0_busy), .done(o0_done), .sum(o0_sum), .cout(o0_cout));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_a8d4 (
    .clk(clk), .rst(rst), .start(st[1]), .a(op_a[1]), .b(op_b[1]), .cin(op_c[1]),
    .busy(o1_busy), .done(o1_done), .sum(o1_sum), .cout(o1_cout));

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_a1d1 (
    .clk(clk), .rst(rst), .start(st[2]), .a(op_a[2][0]), .b(op_b[2][0]), .cin(op_c[2]),
    .busy(o2_busy), .done(o2_done), .sum(o2_sum), .cout(o2_cout));

  always_comb begin
    m_busy[0] = o0_busy; m_done[0] = o0_done; m_cout[0] = o0_cout; m_sum[0] = o0_sum;
    m_busy[1] = o1_busy; m_done[1] = o1_done; m_cout[1] = o1_cout; m_sum[1] = o1_sum;
    m_busy[2] = o2_busy; m_done[2] = o2_done; m_cout[2] = o2_cout; m_sum[2] = {7'd0, o2_sum};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition truncated to the configured width.
  function automatic int ref_sum(int w, logic [7:0] a, logic [7:0] b, logic c);
    int m = (1 << w) - 1;
    return ((int'(a) & m) + (int'(b) & m) + int'(c)) & m;
  endfunction

  function automatic int ref_cout(int w, logic [7:0] a, logic [7:0] b, logic c);
    int m = (1 << w) - 1;
    return (((int'(a) & m) + (int'(b) & m) + int'(c)) >> w) & 1;
  endfunction

  // One addition on instance idx. Operands are scrambled after capture; if
  // poke > 0 a start with fresh operands is pulsed in that RUN cycle.
  task automatic run_add(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input int poke);
    int lat = -1;
    int bc  = 0;
    int extra = 0;
    int es, ec;
    logic [7:0] held;
    string t;
    es = ref_sum(wid[idx], a, b, c);
    ec = ref_cout(wid[idx], a, b, c);
    t  = $sformatf("i%0d %h+%h+%0d", idx, a, b, c);
    @(negedge clk);
    st[idx] = 1'b1; op_a[idx] = a; op_b[idx] = b; op_c[idx] = c;
    @(negedge clk);
    st[idx] = 1'b0;
    op_a[idx] = 8'($urandom); op_b[idx] = 8'($urandom); op_c[idx] = 1'($urandom);
    for (int cyc = 1; cyc <= nd[idx] + 4; cyc++) begin
      if (cyc > 1) @(negedge clk);
      st[idx] = (cyc == poke);
      if (cyc == poke) begin
        op_a[idx] = ~a; op_b[idx] = a ^ b; op_c[idx] = ~c;
      end
      if (m_busy[idx]) bc++;
      if (m_done[idx]) begin
        lat = cyc - 1;
        break;
      end
    end
    st[idx] = 1'b0;
    chk({t, " latency"}, lat, nd[idx]);
    chk({t, " busy cycles"}, bc, nd[idx]);
    chk({t, " sum"}, m_sum[idx], es);
    chk({t, " cout"}, m_cout[idx], ec);
    held = m_sum[idx];
    for (int k = 0; k < nd[idx] + 2; k++) begin
      @(negedge clk);
      if (m_done[idx] || m_busy[idx]) extra++;
    end
    chk({t, " no activity after done"}, extra, 0);
    chk({t, " sum held idle"}, m_sum[idx], held);
    chk({t, " cout held idle"}, m_cout[idx], ec);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; op_c[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d reset busy", i), m_busy[i], 0);
      chk($sformatf("i%0d reset done", i), m_done[i], 0);
      chk($sformatf("i%0d reset sum", i), m_sum[i], 0);
      chk($sformatf("i%0d reset cout", i), m_cout[i], 0);
    end
    rst = 1'b0;

    // Full-adder truth table on the one-bit instance.
    for (int v = 0; v < 8; v++)
      run_add(2, 8'(v & 1), 8'((v >> 1) & 1), 1'((v >> 2) & 1), 0);

    // Directed corner cases.
    run_add(0, 8'hFF, 8'h01, 1'b0, 0);
    chk("FF+01 literal sum", m_sum[0], 32'h00);
    chk("FF+01 literal cout", m_cout[0], 1);
    run_add(1, 8'h7A, 8'h36, 1'b1, 0);
    chk("7A+36+1 literal sum", m_sum[1], 32'hB1);
    chk("7A+36+1 literal cout", m_cout[1], 0);
    run_add(0, 8'hFF, 8'hFF, 1'b1, 0);
    run_add(1, 8'h00, 8'h00, 1'b0, 0);

    // Start pulsed mid-RUN must be ignored.
    run_add(0, 8'h5C, 8'hA7, 1'b0, 3);
    run_add(1, 8'h9E, 8'h81, 1'b1, 1);

    // Back-to-back: start held through DONE on the 8/4 instance.
    begin
      int np = 0;
      int tdone [2];
      logic [7:0] sd [2];
      logic       cd [2];
      @(negedge clk);
      st[1] = 1'b1; op_a[1] = 8'h12; op_b[1] = 8'h34; op_c[1] = 1'b0;
      for (int cyc = 1; cyc <= 3 * nd[1] + 6; cyc++) begin
        @(negedge clk);
        if (cyc == 1) begin
          op_a[1] = 8'hF0; op_b[1] = 8'hF0; op_c[1] = 1'b1;
        end
        if (m_done[1]) begin
          if (np < 2) begin
            tdone[np] = cyc; sd[np] = m_sum[1]; cd[np] = m_cout[1];
          end
          np++;
          if (np == 2) st[1] = 1'b0;
        end
      end
      st[1] = 1'b0;
      chk("b2b done pulses", np, 2);
      if (np >= 2) begin
        chk("b2b spacing", tdone[1] - tdone[0], nd[1] + 1);
        chk("b2b first sum", sd[0], ref_sum(8, 8'h12, 8'h34, 1'b0));
        chk("b2b first cout", cd[0], ref_cout(8, 8'h12, 8'h34, 1'b0));
        chk("b2b second sum", sd[1], ref_sum(8, 8'hF0, 8'hF0, 1'b1));
        chk("b2b second cout", cd[1], ref_cout(8, 8'hF0, 8'hF0, 1'b1));
      end
    end

    // Reset during the third RUN cycle aborts with no done pulse.
    begin
      int nd_after = 0;
      @(negedge clk);
      st[0] = 1'b1; op_a[0] = 8'hC3; op_b[0] = 8'h7E; op_c[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort busy", m_busy[0], 0);
      chk("abort done", m_done[0], 0);
      chk("abort sum", m_sum[0], 0);
      chk("abort cout", m_cout[0], 0);
      rst = 1'b0;
      for (int k = 0; k < nd[0] + 4; k++) begin
        @(negedge clk);
        if (m_done[0]) nd_after++;
      end
      chk("abort no done", nd_after, 0);
    end

    // Randomized additions across all three configurations.
    for (int r = 0; r < 30; r++)
      run_add($urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'($urandom), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
